// File: rtl/ex_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl_pkg
// Shared definitions for the EX-stage hazard/forwarding controller:
//   - FSM state codes (RUN / LWAIT)
//   - select-bit positions used by the EX operand/branch muxes
//   - pipeline stage record carried from EX into WB
//   - a helper that decides whether a used source port reads a given rd
// ----------------------------------------------------------------------------
package ex_hazard_ctrl_pkg;

  // FSM codes kept as plain 1-bit constants so they match the legacy
  // header values bit for bit.
  localparam logic [0:0] HZ_RUN   = 1'b0;
  localparam logic [0:0] HZ_LWAIT = 1'b1;

  // Bit positions inside asel/bsel.
  localparam int SEL_FWD_BIT   = 1;  // forward wb_val into the EX operand
  localparam int SEL_IMMPC_BIT = 0;  // operand A = pc / operand B = imm

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = 5'd0;

  // What EX and WB need to remember about the instruction they hold.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwen;
    logic     is_load;
  } stage_t;

  // True when an actually-used source port names a real register equal to rd.
  // x0 is never a dependency: it is hard-wired to zero.
  function automatic logic reads_reg(input logic     uses,
                                     input reg_idx_t rs,
                                     input reg_idx_t rd);
    return uses && (rs != REG_X0) && (rs == rd);
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl_if
// Bundle between the core datapath (master) and the hazard controller (slave).
//   ID side : id_valid, id_rs1/2, id_rd, id_uses_rs1/2, id_regwen, id_is_load,
//             id_a_pc, id_b_imm
//   control : ex_br_taken (EX redirect), ext_stall (external freeze)
//   results : stall_id, ex_valid, asel, bsel, wb_valid, wb_rd, wb_regwen,
//             perf_stall_cnt, perf_fwd_cnt (zero unless HAZARD_PERF_EN)
// ----------------------------------------------------------------------------
interface ex_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  import ex_hazard_ctrl_pkg::*;

  logic              id_valid;
  reg_idx_t          id_rs1;
  reg_idx_t          id_rs2;
  reg_idx_t          id_rd;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              id_regwen;
  logic              id_is_load;
  logic              id_a_pc;
  logic              id_b_imm;
  logic              ex_br_taken;
  logic              ext_stall;

  logic              stall_id;
  logic              ex_valid;
  logic [1:0]        asel;
  logic [1:0]        bsel;
  logic              wb_valid;
  reg_idx_t          wb_rd;
  logic              wb_regwen;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_fwd_cnt;

  // Core datapath side.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_regwen, id_is_load, id_a_pc, id_b_imm, ex_br_taken, ext_stall,
    input  stall_id, ex_valid, asel, bsel, wb_valid, wb_rd, wb_regwen,
           perf_stall_cnt, perf_fwd_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_regwen, id_is_load, id_a_pc, id_b_imm, ex_br_taken, ext_stall,
    output stall_id, ex_valid, asel, bsel, wb_valid, wb_rd, wb_regwen,
           perf_stall_cnt, perf_fwd_cnt
  );

endinterface

// File: rtl/ex_hazard_ctrl_load_stall_timer.sv
// ----------------------------------------------------------------------------
// load_stall_timer
// Down-counter that times the load-use wait.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : counter may change this cycle (0 = frozen)
//   clr        : force to zero (highest priority when enabled)
//   load       : load load_val
//   dec        : decrement, saturating at zero
//   zero       : count == 0
//   last       : count == 1 (the next decrement empties the counter)
// ----------------------------------------------------------------------------
module load_stall_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (dec && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  assign zero = (count == '0);
  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
// Hazard/forwarding controller for the 3-stage core (ID -> EX -> WB).
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : ex_hazard_ctrl_if.slave (ID fields, redirect, freeze in;
//                stall_id, EX/WB status and registered asel/bsel out)
// Parameters:
//   LOAD_LAT : load-use stall length in cycles (0 = never stall)
//   CNT_W    : load-wait counter width, 2**CNT_W > LOAD_LAT
//   PERF_W   : perf counter width
// Optional feature macro HAZARD_PERF_EN: adds load-stall and forward
// counters; without it the perf outputs are constant zero.
// ----------------------------------------------------------------------------
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LOAD_INIT =
    CNT_W'((LOAD_LAT > 0) ? (LOAD_LAT - 1) : 0);

  stage_t     ex_q;
  stage_t     wb_q;
  logic [1:0] asel_q;
  logic [1:0] bsel_q;
  logic [0:0] state_q;
  logic [0:0] state_nxt;

  logic fwd_a;
  logic fwd_b;
  logic hazard;
  logic load_stall;
  logic issue;
  logic advance;

  logic tmr_clr;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic tmr_last;

  // --------------------------------------------------------------------------
  // Forward and load-use decisions, evaluated against the EX instruction only.
  // WB->ID dependencies are served by the regfile write-through read.
  // --------------------------------------------------------------------------
  assign fwd_a = ex_q.valid && ex_q.regwen &&
                 reads_reg(bus.id_uses_rs1, bus.id_rs1, ex_q.rd);
  assign fwd_b = ex_q.valid && ex_q.regwen &&
                 reads_reg(bus.id_uses_rs2, bus.id_rs2, ex_q.rd);

  assign hazard = (LOAD_LAT > 0) && bus.id_valid && ex_q.valid &&
                  ex_q.is_load && (ex_q.rd != REG_X0) &&
                  (reads_reg(bus.id_uses_rs1, bus.id_rs1, ex_q.rd) ||
                   reads_reg(bus.id_uses_rs2, bus.id_rs2, ex_q.rd));

  assign load_stall = (state_q == HZ_LWAIT) || hazard;
  assign issue      = bus.id_valid && !bus.ex_br_taken && !load_stall;
  assign advance    = !bus.ext_stall;

  // A redirect kills the ID instruction, so there is nothing left to hold.
  // Gated with rst_n so the front end is never held while in reset.
  assign bus.stall_id = rst_n &&
                        (bus.ext_stall || (!bus.ex_br_taken && load_stall));

  // --------------------------------------------------------------------------
  // Load-wait FSM. The detection cycle is the first stall cycle; LWAIT covers
  // the remaining LOAD_LAT-1 cycles and returns to RUN as the counter empties,
  // so a LOAD_LAT of 1 never leaves RUN.
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state_q;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    if (bus.ex_br_taken) begin
      state_nxt = HZ_RUN;
      tmr_clr   = 1'b1;
    end else if (state_q == HZ_LWAIT) begin
      tmr_dec = 1'b1;
      if (tmr_last || tmr_zero) begin
        state_nxt = HZ_RUN;
      end
    end else if (hazard) begin
      tmr_load = 1'b1;
      if (LOAD_LAT > 1) begin
        state_nxt = HZ_LWAIT;
      end
    end
  end

  load_stall_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (advance),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (LOAD_INIT),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  // --------------------------------------------------------------------------
  // Pipe registers. ext_stall freezes everything, including the FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      wb_q    <= '0;
      asel_q  <= 2'b00;
      bsel_q  <= 2'b00;
      state_q <= HZ_RUN;
    end else if (advance) begin
      wb_q    <= ex_q;
      state_q <= state_nxt;
      if (issue) begin
        ex_q <= '{valid: 1'b1, rd: bus.id_rd, regwen: bus.id_regwen,
                  is_load: bus.id_is_load};
        asel_q[SEL_FWD_BIT]   <= fwd_a;
        asel_q[SEL_IMMPC_BIT] <= bus.id_a_pc;
        bsel_q[SEL_FWD_BIT]   <= fwd_b;
        bsel_q[SEL_IMMPC_BIT] <= bus.id_b_imm;
      end else begin
        ex_q   <= '0;
        asel_q <= 2'b00;
        bsel_q <= 2'b00;
      end
    end
  end

  assign bus.ex_valid  = ex_q.valid;
  assign bus.asel      = asel_q;
  assign bus.bsel      = bsel_q;
  assign bus.wb_valid  = wb_q.valid;
  assign bus.wb_rd     = wb_q.rd;
  assign bus.wb_regwen = wb_q.valid && wb_q.regwen && (wb_q.rd != REG_X0);

  // --------------------------------------------------------------------------
  // Optional performance counters (wrap modulo 2**PERF_W, frozen on ext_stall).
  // Only load-use stall cycles are counted, never external freezes.
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_fwd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else if (advance) begin
      if (!bus.ex_br_taken && load_stall) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
      if (issue && (fwd_a || fwd_b)) begin
        perf_fwd_q <= perf_fwd_q + 1'b1;
      end
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_fwd_cnt   = perf_fwd_q;
`else
  assign bus.perf_stall_cnt = {PERF_W{1'b0}};
  assign bus.perf_fwd_cnt   = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_hazard_ctrl
// Directed bench for ex_hazard_ctrl. Two instances share one ID stream:
// dut1 (LOAD_LAT=1) and dut3 (LOAD_LAT=3). Each phase checks only the
// instance it targets. Inputs change 2 time units after the rising edge;
// combinational stall_id is sampled 1 unit later, registered outputs 2 units
// after the following edge. Perf counters are checked against hand counts
// when HAZARD_PERF_EN is defined, otherwise against zero.
// ----------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.PERF_W(32)) bus1 ();
  ex_hazard_ctrl_if #(.PERF_W(32)) bus3 ();

  ex_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(3), .PERF_W(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  ex_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(3), .PERF_W(32)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // dut3 sees exactly the ID stream driven onto bus1.
  assign bus3.id_valid    = bus1.id_valid;
  assign bus3.id_rs1      = bus1.id_rs1;
  assign bus3.id_rs2      = bus1.id_rs2;
  assign bus3.id_rd       = bus1.id_rd;
  assign bus3.id_uses_rs1 = bus1.id_uses_rs1;
  assign bus3.id_uses_rs2 = bus1.id_uses_rs2;
  assign bus3.id_regwen   = bus1.id_regwen;
  assign bus3.id_is_load  = bus1.id_is_load;
  assign bus3.id_a_pc     = bus1.id_a_pc;
  assign bus3.id_b_imm    = bus1.id_b_imm;
  assign bus3.ex_br_taken = bus1.ex_br_taken;
  assign bus3.ext_stall   = bus1.ext_stall;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction plus the control inputs.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic wen, input logic ld, input logic apc,
                       input logic bimm, input logic br, input logic xs);
    bus1.id_valid    = v;
    bus1.id_rs1      = rs1;
    bus1.id_rs2      = rs2;
    bus1.id_rd       = rd;
    bus1.id_uses_rs1 = u1;
    bus1.id_uses_rs2 = u2;
    bus1.id_regwen   = wen;
    bus1.id_is_load  = ld;
    bus1.id_a_pc     = apc;
    bus1.id_b_imm    = bimm;
    bus1.ex_br_taken = br;
    bus1.ext_stall   = xs;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // ---------------- reset state (ext_stall high must not leak out) -------
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check("rst_stall_id", bus1.stall_id, 0);
    check("rst_ex_valid", bus1.ex_valid, 0);
    check("rst_asel", bus1.asel, 0);
    check("rst_bsel", bus1.bsel, 0);
    check("rst_wb_valid", bus1.wb_valid, 0);
    check("rst_wb_rd", bus1.wb_rd, 0);
    check("rst_wb_regwen", bus1.wb_regwen, 0);
    rst_n = 1'b1;
    idle();
    step();

    // ---------------- EX->ID forward: add x1 ; add x2,x1,x3 ----------------
    drive(1'b1, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("fwd_stall_id", bus1.stall_id, 0);
    step();
    check("fwd_asel", bus1.asel, 2'b10);
    check("fwd_bsel", bus1.bsel, 2'b00);
    check("fwd_ex_valid", bus1.ex_valid, 1);
    check("fwd_wb_rd", bus1.wb_rd, 1);
    check("fwd_wb_regwen", bus1.wb_regwen, 1);

    // ---------------- load-use, LOAD_LAT=1: lw x5 ; sw x5,0(x6) ------------
    drive(1'b1, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("lw_asel", bus1.asel, 2'b00);
    check("lw_bsel", bus1.bsel, 2'b01);
    check("lw_wb_rd", bus1.wb_rd, 2);
    drive(1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("lu_stall_id", bus1.stall_id, 1);
    step();
    check("lu_bubble", bus1.ex_valid, 0);
    check("lu_wb_rd", bus1.wb_rd, 5);
    check("lu_wb_regwen", bus1.wb_regwen, 1);
    settle();
    check("lu_release", bus1.stall_id, 0);
    step();
    check("lu_issue_valid", bus1.ex_valid, 1);
    check("lu_issue_bsel", bus1.bsel, 2'b01);
    check("lu_issue_asel", bus1.asel, 2'b00);
    check("lu_wb_bubble", bus1.wb_valid, 0);

    // ---------------- x0 never forwards, never stalls ----------------------
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("x0_asel", bus1.asel, 2'b00);
    check("x0_bsel", bus1.bsel, 2'b00);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("x0_lu_stall", bus1.stall_id, 0);
    step();
    check("x0_lu_issue", bus1.ex_valid, 1);

    // ---------------- both select bits: add x7 ; beq x7,x7 (pc + imm) -------
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("both_asel", bus1.asel, 2'b11);
    check("both_bsel", bus1.bsel, 2'b11);

    // ---------------- branch redirect kills the ID instruction -------------
    drive(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check("br_stall_id", bus1.stall_id, 0);
    step();
    check("br_bubble", bus1.ex_valid, 0);
    check("br_wb_valid", bus1.wb_valid, 1);
    check("br_wb_regwen", bus1.wb_regwen, 0);

    // ---------------- ext_stall freeze with a pending dependency -----------
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("xs_stall_id", bus1.stall_id, 1);
      step();
      check("xs_asel", bus1.asel, 2'b10);
      check("xs_bsel", bus1.bsel, 2'b00);
      check("xs_wb_rd", bus1.wb_rd, 8);
    end
    bus1.ext_stall = 1'b0;
    settle();
    check("xs_release_stall", bus1.stall_id, 0);
    step();
    check("xs_release_asel", bus1.asel, 2'b00);
    check("xs_release_bsel", bus1.bsel, 2'b10);
    check("xs_release_wb_rd", bus1.wb_rd, 9);

    // ---------------- LOAD_LAT=3 (dut3) ------------------------------------
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("l3_stall_id", bus3.stall_id, 1);
      step();
      check("l3_bubble", bus3.ex_valid, 0);
    end
    settle();
    check("l3_release", bus3.stall_id, 0);
    step();
    check("l3_issue_valid", bus3.ex_valid, 1);
    check("l3_issue_asel", bus3.asel, 2'b00);

    // branch in the second stall cycle returns to RUN at once
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("l3b_stall_c1", bus3.stall_id, 1);
    step();
    bus1.ex_br_taken = 1'b1;
    settle();
    check("l3b_stall_br", bus3.stall_id, 0);
    step();
    check("l3b_bubble", bus3.ex_valid, 0);
    bus1.ex_br_taken = 1'b0;
    settle();
    check("l3b_run", bus3.stall_id, 0);
    step();
    check("l3b_issue", bus3.ex_valid, 1);

    // reset in the middle of LWAIT leaves nothing behind
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    settle();
    check("l3r_in_lwait", bus3.stall_id, 1);
    rst_n = 1'b0;
    #1;
    check("l3r_rst_stall", bus3.stall_id, 0);
    check("l3r_rst_ex_valid", bus3.ex_valid, 0);
    step();
    rst_n = 1'b1;
    settle();
    check("l3r_post_stall", bus3.stall_id, 0);
    step();
    check("l3r_post_issue", bus3.ex_valid, 1);

    // ---------------- perf: 10 forwards and 3 load stalls on dut1 ----------
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
    end
    idle();
    step();
`ifdef HAZARD_PERF_EN
    check("perf_fwd_cnt", bus1.perf_fwd_cnt, 10);
    check("perf_stall_cnt", bus1.perf_stall_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("perf_fwd_rst", bus1.perf_fwd_cnt, 0);
    check("perf_stall_rst", bus1.perf_stall_cnt, 0);
`else
    check("perf_fwd_off", bus1.perf_fwd_cnt, 0);
    check("perf_stall_off", bus1.perf_stall_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
